flit_route_decoder: RTL and testbench

Parametrised NoC head-flit decoder and route-compute stage on the router input path, between the input buffer and the switch allocator. Extracts source/destination addresses from head flits, computes the XY output port, and holds that route for the body/tail flits of the same packet. Flits pass through a one-deep registered valid/ready stage, and packet-framing errors are flagged.

---
 rtl/flit_route_decoder.sv | 185 ++++++++++++++++++
 tb/tb_flit_route_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_route_decoder.sv
// flit_route_decoder: NoC head-flit decoder and XY route-compute stage.
// Head/single flits latch the source and destination addresses and compute
// the output port. Body/tail flits reuse that route. Flits pass through one
// registered valid/ready stage. Orphan and truncation framing errors pulse for
// one cycle.
// Optional feature: define FLIT_DEC_STATS_EN to add the saturating pkt_count
// output, which counts completed packets.

module flit_route_decoder #(
    parameter int unsigned          FLIT_W   = 256,
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          TYPE_MSB = 255,
    parameter int unsigned          SRC_MSB  = 247,
    parameter int unsigned          DEST_MSB = 239,
    parameter logic [ADDR_W/2-1:0]  MY_X     = '0,
    parameter logic [ADDR_W/2-1:0]  MY_Y     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dest_addr,
    output logic [2:0]        out_port,
    output logic              out_head,
    output logic              out_tail,
    output logic              err_orphan,
`ifdef FLIT_DEC_STATS_EN
    output logic              err_trunc,
    output logic [15:0]       pkt_count
`else
    output logic              err_trunc
`endif
);

    localparam int unsigned HALF_W = ADDR_W / 2;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_EAST  = 3'd1;
    localparam logic [2:0] PORT_WEST  = 3'd2;
    localparam logic [2:0] PORT_NORTH = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;

    typedef enum logic [0:0] {
        StIdle,
        StPkt
    } state_e;

    state_e              r_state;
    logic [FLIT_W-1:0]   r_out_flit;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_src_addr;
    logic [ADDR_W-1:0]   r_dest_addr;
    logic [2:0]          r_out_port;
    logic                r_out_head;
    logic                r_out_tail;
    logic                r_err_orphan;
    logic                r_err_trunc;

    logic [1:0]          w_type;
    logic                w_is_head;
    logic                w_is_tail;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_src;
    logic [ADDR_W-1:0]   w_dest;
    logic [HALF_W-1:0]   w_dest_x;
    logic [HALF_W-1:0]   w_dest_y;
    logic [2:0]          w_route;

    // Field extraction and handshake. Type bit 0 marks a head, bit 1 a tail.
    always_comb begin
        w_type    = in_flit[TYPE_MSB -: 2];
        w_is_head = w_type[0];
        w_is_tail = w_type[1];
        w_src     = in_flit[SRC_MSB -: ADDR_W];
        w_dest    = in_flit[DEST_MSB -: ADDR_W];
        w_dest_x  = w_dest[HALF_W-1:0];
        w_dest_y  = w_dest[ADDR_W-1:HALF_W];
        in_ready  = !r_out_valid || out_ready;
        w_accept  = in_valid && in_ready;
    end

    // XY dimension-order routing: resolve X first, then Y.
    always_comb begin
        w_route = PORT_LOCAL;
        if (w_dest_x > MY_X) begin
            w_route = PORT_EAST;
        end else if (w_dest_x < MY_X) begin
            w_route = PORT_WEST;
        end else if (w_dest_y > MY_Y) begin
            w_route = PORT_NORTH;
        end else if (w_dest_y < MY_Y) begin
            w_route = PORT_SOUTH;
        end
    end

    // Packet FSM, output stage register and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_out_flit   <= '0;
            r_out_valid  <= 1'b0;
            r_src_addr   <= '0;
            r_dest_addr  <= '0;
            r_out_port   <= PORT_LOCAL;
            r_out_head   <= 1'b0;
            r_out_tail   <= 1'b0;
            r_err_orphan <= 1'b0;
            r_err_trunc  <= 1'b0;
        end else begin
            r_err_orphan <= 1'b0;
            r_err_trunc  <= 1'b0;

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_is_head) begin
                    // Head or single: start a new route; a head inside an
                    // open packet truncates it.
                    r_out_flit  <= in_flit;
                    r_out_valid <= 1'b1;
                    r_out_head  <= 1'b1;
                    r_out_tail  <= w_is_tail;
                    r_src_addr  <= w_src;
                    r_dest_addr <= w_dest;
                    r_out_port  <= w_route;
                    if (r_state == StPkt) begin
                        r_err_trunc <= 1'b1;
                    end
                    r_state <= w_is_tail ? StIdle : StPkt;
                end else if (r_state == StPkt) begin
                    // Body or tail: forward on the held route.
                    r_out_flit  <= in_flit;
                    r_out_valid <= 1'b1;
                    r_out_head  <= 1'b0;
                    r_out_tail  <= w_is_tail;
                    if (w_is_tail) begin
                        r_state <= StIdle;
                    end
                end else begin
                    // Body or tail with no open packet: drop it.
                    r_err_orphan <= 1'b1;
                end
            end
        end
    end

`ifdef FLIT_DEC_STATS_EN
    logic [15:0] r_pkt_count;
    logic        w_pkt_done;

    // A packet completes on a tail inside a packet or on any single flit.
    always_comb begin
        w_pkt_done = w_accept && w_is_tail && (w_is_head || (r_state == StPkt));
    end

    // Saturating completed-packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_count <= '0;
        end else if (w_pkt_done && (r_pkt_count != 16'hFFFF)) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

    assign out_flit   = r_out_flit;
    assign out_valid  = r_out_valid;
    assign src_addr   = r_src_addr;
    assign dest_addr  = r_dest_addr;
    assign out_port   = r_out_port;
    assign out_head   = r_out_head;
    assign out_tail   = r_out_tail;
    assign err_orphan = r_err_orphan;
    assign err_trunc  = r_err_trunc;

endmodule

// File: tb/tb_flit_route_decoder.sv
// Directed testbench for flit_route_decoder with MY_X=2, MY_Y=1.
// Addresses are {Y, X} nibbles, so dest 0x35 is Y=3, X=5.

module tb_flit_route_decoder;

    localparam int unsigned FLIT_W = 256;
    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dest_addr;
    logic [2:0]        out_port;
    logic              out_head;
    logic              out_tail;
    logic              err_orphan;
    logic              err_trunc;
`ifdef FLIT_DEC_STATS_EN
    logic [15:0]       pkt_count;
`endif

    int n_vec;
    int n_err;

    flit_route_decoder #(
        .FLIT_W   (FLIT_W),
        .ADDR_W   (ADDR_W),
        .TYPE_MSB (255),
        .SRC_MSB  (247),
        .DEST_MSB (239),
        .MY_X     (4'd2),
        .MY_Y     (4'd1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_addr   (src_addr),
        .dest_addr  (dest_addr),
        .out_port   (out_port),
        .out_head   (out_head),
        .out_tail   (out_tail),
        .err_orphan (err_orphan),
`ifdef FLIT_DEC_STATS_EN
        .err_trunc  (err_trunc),
        .pkt_count  (pkt_count)
`else
        .err_trunc  (err_trunc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] ty, input logic [7:0] src,
                                             input logic [7:0] dest, input logic [31:0] pay);
        logic [FLIT_W-1:0] f;
        f            = '0;
        f[255:254]   = ty;
        f[247:240]   = src;
        f[239:232]   = dest;
        f[31:0]      = pay;
        return f;
    endfunction

    task automatic check(input string tag, input logic [FLIT_W-1:0] got,
                         input logic [FLIT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [FLIT_W-1:0] f_head;
    logic [FLIT_W-1:0] f_body;
    logic [FLIT_W-1:0] f_tail;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_flit   = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_flit", out_flit, 0);
        check("rst_src", src_addr, 0);
        check("rst_dest", dest_addr, 0);
        check("rst_port", out_port, 0);
        check("rst_head", out_head, 0);
        check("rst_tail", out_tail, 0);
        check("rst_orphan", err_orphan, 0);
        check("rst_trunc", err_trunc, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef FLIT_DEC_STATS_EN
        check("rst_pkt_count", pkt_count, 0);
`endif

        // Single flit, dest X=5 > 2 -> East
        in_flit  = mk(2'b11, 8'hA7, 8'h35, 32'h1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_flit", out_flit, mk(2'b11, 8'hA7, 8'h35, 32'h1));
        check("single_dest", dest_addr, 8'h35);
        check("single_src", src_addr, 8'hA7);
        check("single_port", out_port, 1);
        check("single_head", out_head, 1);
        check("single_tail", out_tail, 1);
`ifdef FLIT_DEC_STATS_EN
        check("single_pkt_count", pkt_count, 1);
`endif
        step();
        check("single_drain", out_valid, 0);

        // Head/body/tail to local (dest 0x12 is X=2, Y=1)
        in_valid = 1'b1;
        in_flit  = mk(2'b01, 8'h44, 8'h12, 32'h2);
        step();
        check("pkt_h_valid", out_valid, 1);
        check("pkt_h_port", out_port, 0);
        check("pkt_h_head", out_head, 1);
        check("pkt_h_tail", out_tail, 0);
        in_flit = mk(2'b00, 8'h00, 8'h00, 32'h3);
        step();
        check("pkt_b_valid", out_valid, 1);
        check("pkt_b_flit", out_flit, mk(2'b00, 8'h00, 8'h00, 32'h3));
        check("pkt_b_port", out_port, 0);
        check("pkt_b_dest", dest_addr, 8'h12);
        check("pkt_b_head", out_head, 0);
        in_flit = mk(2'b10, 8'h00, 8'h00, 32'h4);
        step();
        in_valid = 1'b0;
        check("pkt_t_valid", out_valid, 1);
        check("pkt_t_port", out_port, 0);
        check("pkt_t_tail", out_tail, 1);
        check("pkt_t_src", src_addr, 8'h44);
        step();
        check("pkt_drain", out_valid, 0);

        // Orphan body: the FSM must be back in IDLE after the tail
        in_valid = 1'b1;
        in_flit  = mk(2'b00, 8'h00, 8'h00, 32'h9);
        step();
        in_valid = 1'b0;
        check("orphan_pulse", err_orphan, 1);
        check("orphan_valid", out_valid, 0);
        check("orphan_trunc", err_trunc, 0);
        step();
        check("orphan_clear", err_orphan, 0);
        check("orphan_valid2", out_valid, 0);
`ifdef FLIT_DEC_STATS_EN
        check("orphan_pkt_count", pkt_count, 2);
`endif

        // Back-pressure: head dest 0x21 (X=1 < 2 -> West), then a body held off
        f_head    = mk(2'b01, 8'h11, 8'h21, 32'h5);
        f_body    = mk(2'b00, 8'h00, 8'h00, 32'h6);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_flit   = f_head;
        step();
        in_flit = f_body;
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_port", out_port, 2);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_hold_flit", out_flit, f_head);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_head", out_head, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_body_flit", out_flit, f_body);
        check("bp_body_valid", out_valid, 1);
        check("bp_body_head", out_head, 0);
        check("bp_body_port", out_port, 2);
        f_tail  = mk(2'b10, 8'h00, 8'h00, 32'h7);
        in_flit = f_tail;
        step();
        in_valid = 1'b0;
        check("bp_tail_flit", out_flit, f_tail);
        check("bp_tail_tail", out_tail, 1);
`ifdef FLIT_DEC_STATS_EN
        check("bp_pkt_count", pkt_count, 3);
`endif
        step();

        // Truncation: head dest 0x32 (North) then head dest 0x02 (South)
        in_valid = 1'b1;
        in_flit  = mk(2'b01, 8'h01, 8'h32, 32'hA);
        step();
        check("tr_port_n", out_port, 3);
        check("tr_first_trunc", err_trunc, 0);
        in_flit = mk(2'b01, 8'h02, 8'h02, 32'hB);
        step();
        in_valid = 1'b0;
        check("tr_port_s", out_port, 4);
        check("tr_pulse", err_trunc, 1);
        check("tr_head", out_head, 1);
        check("tr_dest", dest_addr, 8'h02);
        step();
        check("tr_clear", err_trunc, 0);
        // Still inside the second packet: a tail is forwarded, not orphaned
        in_valid = 1'b1;
        in_flit  = mk(2'b10, 8'h00, 8'h00, 32'hC);
        step();
        in_valid = 1'b0;
        check("tr_tail_valid", out_valid, 1);
        check("tr_tail_orphan", err_orphan, 0);
        check("tr_tail_port", out_port, 4);
`ifdef FLIT_DEC_STATS_EN
        check("tr_pkt_count", pkt_count, 4);
`endif
        step();

        // Reset mid-packet
        in_valid = 1'b1;
        in_flit  = mk(2'b01, 8'h66, 8'h55, 32'hD);
        step();
        in_valid = 1'b0;
        check("rmp_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmp_valid0", out_valid, 0);
        check("rmp_flit0", out_flit, 0);
        check("rmp_src0", src_addr, 0);
        check("rmp_dest0", dest_addr, 0);
        check("rmp_port0", out_port, 0);
        check("rmp_head0", out_head, 0);
`ifdef FLIT_DEC_STATS_EN
        check("rmp_pkt_count0", pkt_count, 0);
`endif
        in_valid = 1'b1;
        in_flit  = mk(2'b00, 8'h00, 8'h00, 32'hE);
        step();
        in_valid = 1'b0;
        check("rmp_orphan", err_orphan, 1);
        check("rmp_no_valid", out_valid, 0);

        // Single flit dest 0x30 (X=0 < 2 -> West)
        in_valid = 1'b1;
        in_flit  = mk(2'b11, 8'h01, 8'h30, 32'hF);
        step();
        in_valid = 1'b0;
        check("west_port", out_port, 2);
        check("west_orphan_clear", err_orphan, 0);
`ifdef FLIT_DEC_STATS_EN
        check("west_pkt_count", pkt_count, 1);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
